// File: rtl/d_flop_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : d_flop_pipe_if
// Brief    : Producer/consumer bundle for the d_flop_pipe delay line.
// Revision : 1.0 - initial release
// ============================================================================
interface d_flop_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic             d_valid;
    logic [WIDTH-1:0] d;
    logic             q_valid;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output en, flush, d_valid, d,
        input  q_valid, q, count, rise, fall
    );

    modport slave (
        input  en, flush, d_valid, d,
        output q_valid, q, count, rise, fall
    );
endinterface : d_flop_pipe_if
`default_nettype wire

// File: rtl/d_flop_pipe.sv
`default_nettype none
// ============================================================================
// Module   : d_flop_pipe
// Brief    : WIDTH-bit, DEPTH-stage stallable delay line with valid tracking,
//            flush, occupancy count and optional input edge detection
//            (compiled in with D_FLOP_PIPE_EDGE_DET_EN).
// Revision : 1.0 - initial release
// ============================================================================
module d_flop_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    d_flop_pipe_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (bus.flush) begin
            valid_d = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
        end else if (bus.en) begin
            // Empty slots carry zero data so q reads 0 whenever q_valid is low
            valid_d[0] = bus.d_valid;
            data_d[0]  = bus.d_valid ? bus.d : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
            count_d = count_q + CW'(bus.d_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.q       = data_q[DEPTH-1];
    assign bus.q_valid = valid_q[DEPTH-1];
    assign bus.count   = count_q;

`ifdef D_FLOP_PIPE_EDGE_DET_EN
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // Edges describe the input stream, so they are not delayed to match q
    always_comb begin
        hist_d = hist_q;
        rise_d = rise_q;
        fall_d = fall_q;
        if (bus.flush) begin
            hist_d = '0;
            rise_d = '0;
            fall_d = '0;
        end else if (bus.en) begin
            if (bus.d_valid) begin
                rise_d = bus.d & ~hist_q;
                fall_d = ~bus.d & hist_q;
                hist_d = bus.d;
            end else begin
                rise_d = '0;
                fall_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`else
    assign bus.rise = '0;
    assign bus.fall = '0;
`endif

endmodule : d_flop_pipe
`default_nettype wire

// File: tb/tb_d_flop_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_flop_pipe
// Brief    : Directed self-checking bench for d_flop_pipe (WIDTH=8, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_flop_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef D_FLOP_PIPE_EDGE_DET_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    d_flop_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    d_flop_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] ed(input logic [7:0] x);
        return EDGE_ON ? x : 8'h00;
    endfunction

    // Reference model: the pipe is a fixed-length queue of samples
    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] mhist, mrise, mfall;

    always @(posedge clk or posedge rst) begin : b_model
        ent_t e;
        if (rst || bus.flush) begin
            mq.delete();
            repeat (DEPTH) mq.push_back('0);
            mhist = '0;
            mrise = '0;
            mfall = '0;
        end else if (bus.en) begin
            e.v = bus.d_valid;
            e.d = bus.d_valid ? bus.d : 8'h00;
            mq.push_front(e);
            void'(mq.pop_back());
            if (bus.d_valid) begin
                mrise = bus.d & ~mhist;
                mfall = ~bus.d & mhist;
                mhist = bus.d;
            end else begin
                mrise = '0;
                mfall = '0;
            end
        end
    end

    always @(negedge clk) begin : b_compare
        ent_t tail;
        int   c;
        tail = mq[DEPTH-1];
        c = 0;
        foreach (mq[i]) if (mq[i].v) c++;
        chk("model q_valid", bus.q_valid, tail.v);
        chk("model q", bus.q, tail.d);
        chk("model count", bus.count, c);
        chk("model rise", bus.rise, EDGE_ON ? mrise : 8'h00);
        chk("model fall", bus.fall, EDGE_ON ? mfall : 8'h00);
    end

    task automatic step(input logic e, input logic f, input logic v, input logic [7:0] dd);
        bus.en      = e;
        bus.flush   = f;
        bus.d_valid = v;
        bus.d       = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic qv, input logic [7:0] qq, input int cnt);
        chk({tag, " q_valid"}, bus.q_valid, qv);
        chk({tag, " q"}, bus.q, qq);
        chk({tag, " count"}, bus.count, cnt);
    endtask

    task automatic lit_edge(input string tag, input logic [7:0] r, input logic [7:0] f);
        chk({tag, " rise"}, bus.rise, r);
        chk({tag, " fall"}, bus.fall, f);
    endtask

    initial begin
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.flush   = 1'b0;
        bus.d_valid = 1'b0;
        bus.d       = '0;

        // Asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        lit("reset", 1'b0, 8'h00, 0);
        lit_edge("reset", 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming
        step(1, 0, 1, 8'h11); lit("stream1", 0, 8'h00, 1); lit_edge("stream1", ed(8'h11), 8'h00);
        step(1, 0, 1, 8'h22); lit("stream2", 0, 8'h00, 2);
        step(1, 0, 1, 8'h33); lit("stream3", 0, 8'h00, 3);
        step(1, 0, 1, 8'h44); lit("stream4", 1, 8'h11, 4);
        step(1, 0, 1, 8'h55); lit("stream5", 1, 8'h22, 4);
        step(1, 0, 0, 8'h99); lit("drain1", 1, 8'h33, 3); lit_edge("drain1", 8'h00, 8'h00);
        step(1, 0, 0, 8'h99); lit("drain2", 1, 8'h44, 2);
        step(1, 0, 0, 8'h99); lit("drain3", 1, 8'h55, 1);
        step(1, 0, 0, 8'h99); lit("drain4", 0, 8'h00, 0);

        // Stall
        step(0, 1, 0, 8'h00); lit("stall flush", 0, 8'h00, 0);
        step(1, 0, 1, 8'h11);
        step(1, 0, 1, 8'h22); lit("stall load", 0, 8'h00, 2);
        lit_edge("stall load", ed(8'h22), ed(8'h11));
        repeat (3) begin
            step(0, 0, 1, 8'hEE);
            lit("stall hold", 0, 8'h00, 2);
            lit_edge("stall hold", ed(8'h22), ed(8'h11));
        end
        step(1, 0, 0, 8'h00); lit("stall run1", 0, 8'h00, 2);
        step(1, 0, 0, 8'h00); lit("stall run2", 1, 8'h11, 2);
        step(1, 0, 0, 8'h00); lit("stall run3", 1, 8'h22, 1);
        step(1, 0, 0, 8'h00); lit("stall run4", 0, 8'h00, 0);

        // Bubbles
        step(0, 1, 0, 8'h00);
        step(1, 0, 1, 8'hAA); lit("bub1", 0, 8'h00, 1); lit_edge("bub1", ed(8'hAA), 8'h00);
        step(1, 0, 0, 8'hFF); lit("bub2", 0, 8'h00, 1); lit_edge("bub2", 8'h00, 8'h00);
        step(1, 0, 1, 8'h55); lit("bub3", 0, 8'h00, 2); lit_edge("bub3", ed(8'h55), ed(8'hAA));
        step(1, 0, 0, 8'hFF); lit("bub4", 1, 8'hAA, 2);
        step(1, 0, 0, 8'h00); lit("bub5", 0, 8'h00, 1);
        step(1, 0, 0, 8'h00); lit("bub6", 1, 8'h55, 1);
        step(1, 0, 0, 8'h00); lit("bub7", 0, 8'h00, 0);

        // Flush has priority over enable
        step(1, 0, 1, 8'h01);
        step(1, 0, 1, 8'h02);
        step(1, 0, 1, 8'h03);
        step(1, 0, 1, 8'h04); lit("full", 1, 8'h01, 4);
        step(1, 1, 1, 8'h77); lit("flush", 0, 8'h00, 0); lit_edge("flush", 8'h00, 8'h00);
        repeat (4) begin
            step(1, 0, 0, 8'h00);
            lit("post flush", 0, 8'h00, 0);
        end

        // Edge detection
        step(1, 0, 1, 8'h0F); lit_edge("edge1", ed(8'h0F), 8'h00);
        step(1, 0, 1, 8'h3C); lit_edge("edge2", ed(8'h30), ed(8'h03));
        step(0, 0, 1, 8'hFF); lit_edge("edge hold", ed(8'h30), ed(8'h03));

        // Reset mid-stream discards in-flight samples
        step(1, 0, 1, 8'h5A);
        step(1, 0, 1, 8'hA5);
        #2 rst = 1'b1;
        #1;
        lit("mid reset", 0, 8'h00, 0);
        lit_edge("mid reset", 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            step(1, 0, 0, 8'h00);
            lit("post reset", 0, 8'h00, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule : tb_d_flop_pipe
`default_nettype wire
